// File: rtl/blackjack_round_ctrl.sv
// Blackjack round sequencer: deals cards from the deck to the player and
// dealer hands, applies hit/stand, bust, Charlie and dealer-17 rules.
module blackjack_round_ctrl #(
  parameter int CARD_W       = 4,
  parameter int SUM_W        = 6,
  parameter int DEALER_STAND = 17,
  parameter int BUST_LIMIT   = 21,
  parameter int MAX_CARDS    = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_deal,
  input  logic              i_hit,
  input  logic              i_stand,
  output logic              o_card_req,
  input  logic              i_card_valid,
  input  logic [CARD_W-1:0] i_card,
  output logic [CARD_W-1:0] o_new_card,
  output logic              o_player_add,
  output logic              o_dealer_add,
  output logic              o_hand_clear,
  input  logic [SUM_W-1:0]  i_player_sum,
  input  logic [SUM_W-1:0]  i_dealer_sum,
  input  logic [2:0]        i_player_count,
  input  logic [2:0]        i_dealer_count,
  output logic              o_player_turn,
  output logic              o_round_done,
  output logic [1:0]        o_result
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_ADD, S_CHECK,
    S_PLAYER, S_DEALER, S_SETTLE, S_DONE
  } state_t;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_DEALER = 2'b10;
  localparam logic [1:0] RES_PUSH   = 2'b11;

  localparam logic [SUM_W-1:0] W_BUST  = SUM_W'(BUST_LIMIT);
  localparam logic [SUM_W-1:0] W_STAND = SUM_W'(DEALER_STAND);
  localparam logic [2:0]       W_MAX   = 3'(MAX_CARDS);

  state_t            r_state, w_next;
  logic              r_target, w_target;
  logic [2:0]        r_idx, w_idx;
  logic [1:0]        r_result, w_result;
  logic [CARD_W-1:0] r_card;
  logic              r_done;
  logic              w_xfer;

  assign w_xfer = (r_state == S_FETCH) && i_card_valid;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_target <= 1'b0;
      r_idx    <= 3'd0;
      r_result <= RES_NONE;
      r_card   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_target <= w_target;
      r_idx    <= w_idx;
      r_result <= w_result;
      r_done   <= (r_state == S_SETTLE);
      if (w_xfer) r_card <= i_card;
    end
  end

  // r_target: 0 = player, 1 = dealer; r_idx counts the four opening cards
  always_comb begin
    w_next   = r_state;
    w_target = r_target;
    w_idx    = r_idx;
    w_result = r_result;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (i_deal) begin
          w_result = RES_NONE;
          w_next   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_idx    = 3'd0;
        w_target = 1'b0;
        w_next   = S_FETCH;
      end
      S_FETCH: if (i_card_valid) w_next = S_ADD;
      S_ADD:   w_next = S_CHECK;
      S_CHECK: begin
        if (r_idx < 3'd4) begin
          w_idx = r_idx + 3'd1;
          if (r_idx == 3'd3) begin
            w_next = S_PLAYER;
          end else begin
            w_target = ~r_target;
            w_next   = S_FETCH;
          end
        end else begin
          w_next = r_target ? S_DEALER : S_PLAYER;
        end
      end
      S_PLAYER: begin
        if (i_player_sum > W_BUST) begin
          w_result = RES_DEALER;
          w_next   = S_SETTLE;
        end else if (i_player_count == W_MAX) begin
          w_result = RES_PLAYER;
          w_next   = S_SETTLE;
        end else if (i_player_sum == W_BUST) begin
          w_next = S_DEALER;
        end else if (i_stand) begin
          w_next = S_DEALER;
        end else if (i_hit) begin
          w_target = 1'b0;
          w_next   = S_FETCH;
        end
      end
      S_DEALER: begin
        if (i_dealer_sum > W_BUST) begin
          w_result = RES_PLAYER;
          w_next   = S_SETTLE;
        end else if (i_dealer_sum < W_STAND &&
                     i_dealer_count < W_MAX) begin
          w_target = 1'b1;
          w_next   = S_FETCH;
        end else begin
          w_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_result == RES_NONE) begin
          if (i_player_sum > i_dealer_sum)
            w_result = RES_PLAYER;
          else if (i_dealer_sum > i_player_sum)
            w_result = RES_DEALER;
          else
            w_result = RES_PUSH;
        end
        w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_card_req    = (r_state == S_FETCH);
  assign o_new_card    = r_card;
  assign o_player_add  = (r_state == S_ADD) && !r_target;
  assign o_dealer_add  = (r_state == S_ADD) && r_target;
  assign o_hand_clear  = (r_state == S_CLEAR);
  assign o_player_turn = (r_state == S_PLAYER);
  assign o_round_done  = r_done;
  assign o_result      = r_result;

endmodule
